// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with synchronous load and registered carry/borrow/load_err pulses.
// Digits ripple internally; tc is combinational so instances can be cascaded through en.
module bcd_updown_counter #(
  parameter int DIGITS   = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  carry,
  output logic                  borrow,
  output logic                  tc,
  output logic                  load_err
);

  localparam int W = 4 * DIGITS;

  // pre9[i] / pre0[i]: digits 0..i-1 are all 9 / all 0, so digit i steps this cycle.
  logic [DIGITS:0] pre9;
  logic [DIGITS:0] pre0;
  logic [W-1:0]    stepped;
  logic            load_ok;
  logic            at_term;

  always_comb begin
    pre9     = '0;
    pre0     = '0;
    pre9[0]  = 1'b1;
    pre0[0]  = 1'b1;
    stepped  = count;
    load_ok  = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      pre9[i+1] = pre9[i] & (count[4*i +: 4] == 4'd9);
      pre0[i+1] = pre0[i] & (count[4*i +: 4] == 4'd0);
      if (load_val[4*i +: 4] > 4'd9) load_ok = 1'b0;
      if (up && pre9[i])
        stepped[4*i +: 4] = (count[4*i +: 4] == 4'd9) ? 4'd0 : count[4*i +: 4] + 4'd1;
      else if (!up && pre0[i])
        stepped[4*i +: 4] = (count[4*i +: 4] == 4'd0) ? 4'd9 : count[4*i +: 4] - 4'd1;
    end
    at_term = up ? pre9[DIGITS] : pre0[DIGITS];
  end

  assign tc = en & ~load & at_term;

  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= '0;
      carry    <= 1'b0;
      borrow   <= 1'b0;
      load_err <= 1'b0;
    end else begin
      carry    <= 1'b0;
      borrow   <= 1'b0;
      load_err <= 1'b0;
      if (load) begin
        if (load_ok) count <= load_val;
        else         load_err <= 1'b1;
      end else if (en) begin
        // The ripple already yields the wrapped value at terminal; saturation just holds.
        if (!(SATURATE && at_term)) count <= stepped;
        carry  <= up & at_term;
        borrow <= ~up & at_term;
      end
    end
  end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Bench for bcd_updown_counter: three instances (2-digit wrap, 3-digit wrap, 2-digit saturate)
// share stimulus; a decimal-arithmetic model fills an expected queue checked after each edge.
module tb_bcd_updown_counter;

  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b0;
  logic        en    = 1'b0;
  logic        up    = 1'b1;
  logic        load  = 1'b0;
  logic [11:0] load_val = '0;

  logic [7:0]  cnt_a, cnt_s;
  logic [11:0] cnt_b;
  logic carry_a, borrow_a, tc_a, lerr_a;
  logic carry_b, borrow_b, tc_b, lerr_b;
  logic carry_s, borrow_s, tc_s, lerr_s;

  bcd_updown_counter #(.DIGITS(2), .SATURATE(1'b0)) dut_a (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val[7:0]),
    .count(cnt_a), .carry(carry_a), .borrow(borrow_a), .tc(tc_a), .load_err(lerr_a));

  bcd_updown_counter #(.DIGITS(3), .SATURATE(1'b0)) dut_b (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
    .count(cnt_b), .carry(carry_b), .borrow(borrow_b), .tc(tc_b), .load_err(lerr_b));

  bcd_updown_counter #(.DIGITS(2), .SATURATE(1'b1)) dut_s (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val[7:0]),
    .count(cnt_s), .carry(carry_s), .borrow(borrow_s), .tc(tc_s), .load_err(lerr_s));

  int          digits [N] = '{2, 3, 2};
  bit          sat    [N] = '{1'b0, 1'b0, 1'b1};
  logic [11:0] m_cnt  [N] = '{12'h0, 12'h0, 12'h0};
  logic [14:0] exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic int bcd2int(logic [11:0] v, int d);
    int r = 0;
    for (int i = d - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [11:0] int2bcd(int n, int d);
    logic [11:0] r = '0;
    for (int i = 0; i < d; i++) begin
      r[4*i +: 4] = 4'(n % 10);
      n = n / 10;
    end
    return r;
  endfunction

  function automatic logic [14:0] obs(int k);
    case (k)
      0:       return {4'h0, cnt_a, carry_a, borrow_a, lerr_a};
      1:       return {cnt_b, carry_b, borrow_b, lerr_b};
      default: return {4'h0, cnt_s, carry_s, borrow_s, lerr_s};
    endcase
  endfunction

  function automatic logic obs_tc(int k);
    case (k)
      0:       return tc_a;
      1:       return tc_b;
      default: return tc_s;
    endcase
  endfunction

  task automatic check(input string tag, input logic [14:0] o, input logic [14:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // One clock: drive inputs, check tc, run the model, then compare registered outputs.
  task automatic cyc(input string tag, input logic r, input logic l, input logic [11:0] lv,
                     input logic e, input logic u);
    int v, mod, term;
    logic cy, bw, le, ok;
    logic [11:0] lvs;
    @(negedge clk);
    reset = r; load = l; load_val = lv; en = e; up = u;
    #1;
    for (int k = 0; k < N; k++) begin
      v    = bcd2int(m_cnt[k], digits[k]);
      mod  = 10 ** digits[k];
      term = u ? mod - 1 : 0;
      check($sformatf("%s_tc%0d", tag, k), {14'h0, obs_tc(k)},
            {14'h0, e & ~l & (v == term)});
      cy = 1'b0; bw = 1'b0; le = 1'b0;
      lvs = '0;
      ok  = 1'b1;
      for (int i = 0; i < digits[k]; i++) begin
        lvs[4*i +: 4] = lv[4*i +: 4];
        if (lv[4*i +: 4] > 4'd9) ok = 1'b0;
      end
      if (r) begin
        m_cnt[k] = '0;
      end else if (l) begin
        if (ok) m_cnt[k] = lvs;
        else    le = 1'b1;
      end else if (e) begin
        if (v == term) begin
          cy = u; bw = ~u;
          if (!sat[k]) m_cnt[k] = int2bcd(u ? 0 : mod - 1, digits[k]);
        end else begin
          m_cnt[k] = int2bcd(u ? v + 1 : v - 1, digits[k]);
        end
      end
      exp_q.push_back({m_cnt[k], cy, bw, le});
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++)
      check($sformatf("%s_out%0d", tag, k), obs(k), exp_q.pop_front());
  endtask

  initial begin
    logic [11:0] lv;
    // Reset, then count to 37 and reset mid-count.
    cyc("rst0", 1, 0, 12'h000, 0, 1);
    check("rst0_a", obs(0), 15'h0);
    cyc("ld35", 0, 1, 12'h035, 0, 1);
    cyc("up36", 0, 0, 12'h000, 1, 1);
    cyc("up37", 0, 0, 12'h000, 1, 1);
    check("at37_a", obs(0), {4'h0, 8'h37, 3'b000});
    cyc("rst1", 1, 0, 12'h000, 1, 1);
    check("rst1_a", obs(0), 15'h0);

    // Up wrap.
    cyc("ld98", 0, 1, 12'h098, 0, 1);
    cyc("upw1", 0, 0, 12'h000, 1, 1);
    check("upw99_a", obs(0), {4'h0, 8'h99, 3'b000});
    check("upw99_tc", {14'h0, tc_a}, 15'h1);
    cyc("upw2", 0, 0, 12'h000, 1, 1);
    check("upw00_a", obs(0), {4'h0, 8'h00, 3'b100});
    cyc("upw3", 0, 0, 12'h000, 1, 1);
    check("upw01_a", obs(0), {4'h0, 8'h01, 3'b000});

    // Down wrap.
    cyc("ld01", 0, 1, 12'h001, 0, 0);
    cyc("dnw1", 0, 0, 12'h000, 1, 0);
    cyc("dnw2", 0, 0, 12'h000, 1, 0);
    check("dnw99_a", obs(0), {4'h0, 8'h99, 3'b010});
    cyc("dnw3", 0, 0, 12'h000, 1, 0);
    check("dnw98_a", obs(0), {4'h0, 8'h98, 3'b000});

    // Invalid then valid load on the 3-digit instance.
    cyc("ld123", 0, 1, 12'h123, 0, 1);
    cyc("ld1a9", 0, 1, 12'h1A9, 1, 1);
    check("bad_b", obs(1), {12'h123, 3'b001});
    cyc("ld909", 0, 1, 12'h909, 0, 1);
    check("ok_b", obs(1), {12'h909, 3'b000});

    // Priority: load over en, reset over load.
    cyc("ld50en", 0, 1, 12'h050, 1, 1);
    check("prio_a", obs(0), {4'h0, 8'h50, 3'b000});
    cyc("rstld", 1, 1, 12'h077, 1, 1);
    check("rstld_a", obs(0), 15'h0);

    // Saturation at 99, then step down.
    cyc("ld99", 0, 1, 12'h099, 0, 1);
    for (int i = 0; i < 3; i++) begin
      cyc("sat", 0, 0, 12'h000, 1, 1);
      check("sat_s", obs(2), {4'h0, 8'h99, 3'b100});
    end
    cyc("satdn", 0, 0, 12'h000, 1, 0);
    check("satdn_s", obs(2), {4'h0, 8'h98, 3'b000});

    // Saturation at 0 going down.
    cyc("ld00", 0, 1, 12'h000, 0, 0);
    cyc("sat0", 0, 0, 12'h000, 1, 0);
    check("sat0_s", obs(2), {4'h0, 8'h00, 3'b010});

    // Random mix, with loads biased toward terminal values.
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0:       lv = 12'h999;
        1:       lv = 12'h000;
        default: for (int i = 0; i < 3; i++)
                   lv[4*i +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                               : 4'($urandom_range(0, 9));
      endcase
      cyc("rnd", ($urandom_range(0, 29) == 0), ($urandom_range(0, 9) == 0), lv,
          ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
